// File: rtl/sw_conditioner_if.sv
// Switch-conditioner bus: raw switches in, conditioned levels plus the
// captured operand and its valid/ack handshake out.
interface sw_conditioner_if #(
    parameter int n_sw = 9
);
    logic [n_sw-1:0] sw_raw;
    logic [n_sw-1:0] sw_clean;
    logic [n_sw-2:0] data_out;
    logic            valid;
    logic            ack;

    modport master (
        input  sw_raw,
        input  ack,
        output sw_clean,
        output data_out,
        output valid
    );

    modport slave (
        output sw_raw,
        output ack,
        input  sw_clean,
        input  data_out,
        input  valid
    );
endinterface

// File: rtl/sw_conditioner.sv
// Switch front end for picoMIPS: per-bit synchroniser and debounce filter,
// plus a strobe-driven operand capture with a valid/ack handshake.
module sw_conditioner #(
    parameter  int n_sw      = 9,
    parameter  int db_cycles = 16,
    localparam int cnt_w     = $clog2(db_cycles + 1)
) (
    input  logic              clk,
    input  logic              n_reset,
    sw_conditioner_if.master  bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] FULL = 1'b1;
    localparam logic [cnt_w-1:0] cnt_last = cnt_w'(db_cycles - 1);

    logic [n_sw-1:0]  s1_r;
    logic [n_sw-1:0]  s2_r;
    logic [cnt_w-1:0] cnt_r [n_sw];
    logic [n_sw-1:0]  sw_clean_r;
    logic             strobe_q_r;
    logic [n_sw-2:0]  data_r;
    logic [0:0]       state_r;

    logic             rise_s;
    logic [0:0]       state_nxt_s;
    logic [n_sw-2:0]  data_nxt_s;

    // Two-flop synchroniser and per-bit stable-count debounce filter.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            s1_r       <= {n_sw{1'b0}};
            s2_r       <= {n_sw{1'b0}};
            sw_clean_r <= {n_sw{1'b0}};
            for (int i = 0; i < n_sw; i++) begin
                cnt_r[i] <= {cnt_w{1'b0}};
            end
        end else begin
            s1_r <= bus.sw_raw;
            s2_r <= s1_r;
            for (int i = 0; i < n_sw; i++) begin
                if (s2_r[i] == sw_clean_r[i]) begin
                    cnt_r[i] <= {cnt_w{1'b0}};
                end else if (cnt_r[i] == cnt_last) begin
                    sw_clean_r[i] <= s2_r[i];
                    cnt_r[i]      <= {cnt_w{1'b0}};
                end else begin
                    cnt_r[i] <= cnt_r[i] + cnt_w'(1);
                end
            end
        end
    end

    // Edge uses the current clean strobe, so data settling alongside it is captured.
    assign rise_s = sw_clean_r[n_sw-1] & ~strobe_q_r;

    // Handshake next-state: a new rise always wins over ack (newest data kept).
    always_comb begin
        state_nxt_s = state_r;
        data_nxt_s  = data_r;
        case (state_r)
            IDLE: begin
                if (rise_s) begin
                    data_nxt_s  = sw_clean_r[n_sw-2:0];
                    state_nxt_s = FULL;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            FULL: begin
                if (rise_s) begin
                    data_nxt_s  = sw_clean_r[n_sw-2:0];
                    state_nxt_s = FULL;
                end else if (bus.ack) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = FULL;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Strobe history and handshake registers.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            strobe_q_r <= 1'b0;
            data_r     <= {(n_sw-1){1'b0}};
            state_r    <= IDLE;
        end else begin
            strobe_q_r <= sw_clean_r[n_sw-1];
            data_r     <= data_nxt_s;
            state_r    <= state_nxt_s;
        end
    end

    assign bus.sw_clean = sw_clean_r;
    assign bus.data_out = data_r;
    assign bus.valid    = (state_r == FULL);
endmodule

// File: tb/tb_sw_conditioner.sv
// Directed and randomized checks of sw_conditioner against a history-based
// reference model (db_cycles=4, n_sw=9).
module tb_sw_conditioner;
    localparam int DB = 4;

    logic clk = 1'b0;
    logic n_reset = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    sw_conditioner_if #(.n_sw(9)) bus ();

    sw_conditioner #(.n_sw(9), .db_cycles(DB)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Reference model: a bit flips once its last DB synchronised samples all disagree.
    logic [8:0] m_s1, m_s2, m_clean, m_nclean;
    logic       m_sq, m_valid;
    logic [7:0] m_data;
    logic [8:0] hist [$];

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic rise;
        bit   all_diff;
        @(posedge clk);
        if (!n_reset) begin
            m_s1 = '0; m_s2 = '0; m_clean = '0; m_sq = 1'b0;
            m_data = '0; m_valid = 1'b0;
            hist.delete();
        end else begin
            rise = m_clean[8] & ~m_sq;
            if (rise) begin
                m_data  = m_clean[7:0];
                m_valid = 1'b1;
            end else if (m_valid && bus.ack) begin
                m_valid = 1'b0;
            end
            hist.push_back(m_s2);
            if (hist.size() > DB) void'(hist.pop_front());
            m_nclean = m_clean;
            for (int i = 0; i < 9; i++) begin
                all_diff = (hist.size() == DB);
                foreach (hist[k]) if (hist[k][i] == m_clean[i]) all_diff = 1'b0;
                if (all_diff) m_nclean[i] = ~m_clean[i];
            end
            m_sq    = m_clean[8];
            m_clean = m_nclean;
            m_s2    = m_s1;
            m_s1    = bus.sw_raw;
        end
        #1;
        chk("model_clean", bus.sw_clean, m_clean);
        chk("model_valid", {8'h00, bus.valid}, {8'h00, m_valid});
        chk("model_data", {1'b0, bus.data_out}, {1'b0, m_data});
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int dwell;
        bus.sw_raw = 9'h1FF;
        bus.ack    = 1'b0;
        n_reset    = 1'b0;
        m_s1 = '0; m_s2 = '0; m_clean = '0; m_sq = 1'b0; m_data = '0; m_valid = 1'b0;

        // Reset holds everything at zero despite raw all-ones
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_clean", bus.sw_clean, 9'h000);
            chk("rst_valid", {8'h00, bus.valid}, 9'h000);
            chk("rst_data", {1'b0, bus.data_out}, 9'h000);
        end
        n_reset = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("rel_wait", bus.sw_clean, 9'h000);
        end
        step();
        chk("rel_settle", bus.sw_clean, 9'h1FF);
        step();
        chk("rel_valid", {8'h00, bus.valid}, 9'h001);
        chk("rel_data", {1'b0, bus.data_out}, 9'h0FF);
        bus.ack = 1'b1; step(); bus.ack = 1'b0;
        chk("rel_ack", {8'h00, bus.valid}, 9'h000);

        // Bounce rejection on bit 0
        bus.sw_raw = 9'h000; steps(10);
        bus.sw_raw = 9'h001; steps(2);
        bus.sw_raw = 9'h000; steps(2);
        chk("bounce_hold", bus.sw_clean, 9'h000);
        bus.sw_raw = 9'h001;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("bounce_wait", bus.sw_clean, 9'h000);
        end
        step();
        chk("bounce_rise", bus.sw_clean, 9'h001);

        // Capture A5 on strobe rise, then ack
        bus.sw_raw = 9'h0A5; steps(10);
        bus.sw_raw = 9'h1A5; steps(6);
        chk("cap_clean8", bus.sw_clean, 9'h1A5);
        chk("cap_pre", {8'h00, bus.valid}, 9'h000);
        step();
        chk("cap_valid", {8'h00, bus.valid}, 9'h001);
        chk("cap_data", {1'b0, bus.data_out}, 9'h0A5);
        bus.ack = 1'b1; step(); bus.ack = 1'b0;
        chk("ack_valid", {8'h00, bus.valid}, 9'h000);
        chk("ack_data", {1'b0, bus.data_out}, 9'h0A5);

        // Overwrite while FULL
        bus.sw_raw = 9'h0A5; steps(8);
        bus.sw_raw = 9'h1A5; steps(8);
        chk("ovw_full", {8'h00, bus.valid}, 9'h001);
        bus.sw_raw = 9'h03C; steps(8);
        chk("ovw_hold", {1'b0, bus.data_out}, 9'h0A5);
        bus.sw_raw = 9'h13C; steps(8);
        chk("ovw_valid", {8'h00, bus.valid}, 9'h001);
        chk("ovw_data", {1'b0, bus.data_out}, 9'h03C);

        // Ack in the same cycle as a new rise
        bus.sw_raw = 9'h00F; steps(8);
        bus.sw_raw = 9'h10F; steps(6);
        bus.ack = 1'b1; step(); bus.ack = 1'b0;
        chk("sim_valid", {8'h00, bus.valid}, 9'h001);
        chk("sim_data", {1'b0, bus.data_out}, 9'h00F);
        bus.ack = 1'b1; step();
        chk("sim_ack", {8'h00, bus.valid}, 9'h000);
        step(); bus.ack = 1'b0;
        chk("idle_ack", {8'h00, bus.valid}, 9'h000);
        chk("idle_data", {1'b0, bus.data_out}, 9'h00F);

        // Reset with bit 3 mid-debounce and valid set
        bus.sw_raw = 9'h00F; steps(8);
        bus.sw_raw = 9'h10F; steps(8);
        bus.sw_raw = 9'h107; steps(4);
        chk("mid_pre", {8'h00, bus.valid}, 9'h001);
        n_reset = 1'b0; step();
        chk("mid_valid", {8'h00, bus.valid}, 9'h000);
        chk("mid_data", {1'b0, bus.data_out}, 9'h000);
        chk("mid_clean", bus.sw_clean, 9'h000);
        n_reset = 1'b1;
        steps(5);
        chk("mid_wait", bus.sw_clean, 9'h000);
        step();
        chk("mid_settle", bus.sw_clean, 9'h107);

        // Randomized traffic with bounces, acks and occasional resets
        for (int s = 0; s < 80; s++) begin
            if ($urandom_range(0, 2) == 0)
                bus.sw_raw = bus.sw_raw ^ 9'h100;
            else
                bus.sw_raw = 9'($urandom_range(0, 511));
            dwell = $urandom_range(1, 9);
            for (int d = 0; d < dwell; d++) begin
                bus.ack = ($urandom_range(0, 2) == 0);
                n_reset = ($urandom_range(0, 59) != 0);
                step();
            end
        end
        n_reset = 1'b1;
        bus.ack = 1'b0;
        steps(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sw_conditioner.md
Name: sw_conditioner

Overview:
- Front-end stage that sits directly upstream of the picoMIPS CPU. It takes the raw board switches SW[8:0] and delivers conditioned switch values to the CPU's `switches` input.
- Per-bit processing: two-flop synchronisation, then a stable-count debounce filter.
- The top switch (strobe bit) is turned into a valid/ack handshake. The operand on the lower bits is captured at the strobe's rising edge, so program code can poll for a fresh input word.

Parameters:
- n_sw, 9, total switch bits handled; bit n_sw-1 is the strobe.
- db_cycles, 16, consecutive stable cycles required before a clean bit changes; legal range 2..65535.
- cnt_w, $clog2(db_cycles+1), debounce counter width (derived, not overridden).

Ports:
- clk  input  1  system clock; all flops on the rising edge.
- n_reset  input  1  synchronous, active-low reset.
- sw_raw  input  n_sw  asynchronous board switches.
- sw_clean  output  n_sw  debounced switch levels, driven to CPU `switches`.
- data_out  output  n_sw-1  operand sw_clean[n_sw-2:0], latched on the strobe rising edge.
- valid  output  1  a new operand is held in data_out.
- ack  input  1  consumer has taken data_out; sampled only while valid=1.

Behaviour:
- Reset: sampled on the clk edge while n_reset=0. The following are cleared:
  - sync stages s1, s2
  - all debounce counters
  - sw_clean, strobe history flop, data_out, valid
- Reset overrides every other action. Reset in mid-debounce discards the count.
- Synchroniser: per bit, s1<=sw_raw, s2<=s1. No logic sits between s1 and s2.
- Debounce, per bit i, independent:
  - If s2[i]==sw_clean[i]: cnt[i]<=0.
  - Else if cnt[i]==db_cycles-1: sw_clean[i]<=s2[i], cnt[i]<=0.
  - Else: cnt[i]<=cnt[i]+1.
  - A glitch shorter than db_cycles cycles at s2 produces no output change. The counter restarts on every bounce.
  - Latency: a raw change that stays stable appears on sw_clean exactly db_cycles+2 cycles after the first rising edge that samples the new value.
  - The counter never exceeds db_cycles-1 and never wraps.
- Strobe edge: rise = sw_clean[n_sw-1] & ~strobe_q; strobe_q<=sw_clean[n_sw-1] each cycle. Falling edges produce no action.
- Handshake state machine, two states:
  - IDLE (valid=0): on rise, data_out<=sw_clean[n_sw-2:0] and go to FULL. ack is ignored in IDLE.
  - FULL (valid=1):
    - rise with ack, or rise alone: recapture data_out and stay FULL. Newest data wins; the old word is overwritten without an error flag.
    - ack without rise: go to IDLE; data_out holds its value.
  - valid is a registered output and is 1 exactly in FULL.
- Lower bits changing while valid=1 do not alter data_out. data_out changes only on rise.
- sw_clean is always live, so CPU code that ignores the handshake still sees levels.
- The clean edge used for capture is computed from sw_clean of the same cycle. Data bits and the strobe settling in the same cycle therefore capture the settled data.

Test Plan (bench uses db_cycles=4, n_sw=9):
- Reset: drive sw_raw=9'h1FF, hold n_reset=0 for 3 cycles -> sw_clean=0, valid=0, data_out=0 throughout. Release reset -> sw_clean=9'h1FF exactly 6 cycles later.
- Bounce rejection: toggle sw_raw[0] 0→1→0→1 with 2-cycle dwell, then hold 1 -> sw_clean[0] stays 0 during bouncing and rises 6 cycles after the final transition.
- Capture: set sw_raw[7:0]=8'hA5, wait 10 cycles, raise sw_raw[8] -> valid=1 with data_out=8'hA5 on the cycle after sw_clean[8] rises. Pulse ack for 1 cycle -> valid=0 next cycle, data_out still 8'hA5.
- Overwrite: while valid=1 with 8'hA5, drop the strobe, set 8'h3C, raise the strobe with no ack -> valid stays 1, data_out=8'h3C.
- Simultaneous: assert ack on the same cycle as a new strobe rise carrying 8'h0F -> valid stays 1, data_out=8'h0F. ack while IDLE -> no change.
- Mid-operation reset: assert n_reset=0 when cnt[3]=2 and valid=1 -> next cycle valid=0, data_out=0, sw_clean=0. After release, a full 6-cycle debounce is needed again.
